// File: rtl/chacha_stream_xor_pkg.sv
// Shared constants and FSM state encoding for the ChaCha
// keystream XOR stream engine.
package chacha_stream_xor_pkg;

    localparam int KS_WORDS = 16;
    localparam int WORD_W   = 32;
    localparam int BLK_W    = 512;
    localparam int IDX_W    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_REQ,
        S_WAIT_KS,
        S_STREAM,
        S_NEXT_REQ,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/chacha_ks_buf.sv
// Keystream block buffer: holds one 512-bit block and
// selects the 32-bit word addressed by the running index.
module chacha_ks_buf
    import chacha_stream_xor_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              adv_i,
    input  logic [BLK_W-1:0]  blk_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic [WORD_W-1:0] word_o
);

    logic [BLK_W-1:0] buf_q;
    logic [BLK_W-1:0] buf_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // Next-state: clear wins over load, load wins over advance.
    always_comb begin
        buf_d = buf_q;
        idx_d = idx_q;
        if (clear_i) begin
            buf_d = '0;
            idx_d = '0;
        end else if (load_i) begin
            buf_d = blk_i;
            idx_d = '0;
        end else if (adv_i) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Buffer and index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q <= '0;
            idx_q <= '0;
        end else begin
            buf_q <= buf_d;
            idx_q <= idx_d;
        end
    end

    // Word 0 sits in the most significant 32 bits of the block.
    always_comb begin
        word_o = '0;
        for (int i = 0; i < KS_WORDS; i++) begin
            if (idx_q == i[IDX_W-1:0])
                word_o = buf_q[BLK_W-1-WORD_W*i -: WORD_W];
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/chacha_stream_xor.sv
// Streams 32-bit words through an XOR with keystream blocks
// requested from an external ChaCha core.
module chacha_stream_xor
    import chacha_stream_xor_pkg::*;
#(
    parameter int MAX_BLOCKS = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              core_init,
    output logic              core_next,
    input  logic              core_ready,
    input  logic [BLK_W-1:0]  core_data_out,
    input  logic              core_data_out_valid,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic [15:0]       blk_cnt,
    output logic              err
);

    localparam bit          LIMIT = (MAX_BLOCKS != 0);
    localparam logic [15:0] MAX_B = 16'(MAX_BLOCKS);

    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [15:0]         blk_cnt_q, blk_cnt_d;
    logic                err_q, err_d;

    logic                buf_load;
    logic                buf_clear;
    logic                buf_adv;
    logic [IDX_W-1:0]    idx;
    logic [WORD_W-1:0]   ks_word;
    logic                hs;

    chacha_ks_buf u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .adv_i   (buf_adv),
        .blk_i   (core_data_out),
        .idx_o   (idx),
        .word_o  (ks_word)
    );

    // Session FSM, core request pulses and output word staging.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        blk_cnt_d   = blk_cnt_q;
        err_d       = err_q;
        core_init   = 1'b0;
        core_next   = 1'b0;
        in_ready    = 1'b0;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        buf_adv     = 1'b0;
        hs          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_INIT_REQ;
                    blk_cnt_d = '0;
                    err_d     = 1'b0;
                    buf_clear = 1'b1;
                end
            end
            S_INIT_REQ: begin
                if (core_ready) begin
                    core_init = 1'b1;
                    state_d   = S_WAIT_KS;
                end
            end
            S_WAIT_KS: begin
                if (core_ready && core_data_out_valid) begin
                    buf_load = 1'b1;
                    state_d  = S_STREAM;
                    if (blk_cnt_q != 16'hFFFF)
                        blk_cnt_d = blk_cnt_q + 16'd1;
                end
            end
            S_STREAM: begin
                in_ready = !out_valid_q || out_ready;
                if (in_valid && in_ready) begin
                    hs      = 1'b1;
                    buf_adv = 1'b1;
                    if (in_last) begin
                        state_d = S_DRAIN;
                    end else if (idx == IDX_W'(KS_WORDS-1)) begin
                        if (LIMIT && blk_cnt_q == MAX_B) begin
                            state_d = S_DRAIN;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_NEXT_REQ;
                        end
                    end
                end
            end
            S_NEXT_REQ: begin
                if (core_ready) begin
                    core_next = 1'b1;
                    state_d   = S_WAIT_KS;
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    state_d   = S_IDLE;
                    buf_clear = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hs) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ ks_word;
            out_last_d  = in_last;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            blk_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            blk_cnt_q   <= blk_cnt_d;
            err_q       <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign blk_cnt   = blk_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Bench for chacha_stream_xor: unlimited and one-block
// instances driven by a shared stream and stub cores.
module tb_chacha_stream_xor;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [31:0]  in_data = '0;
    logic         out_ready = 1'b1;
    logic         hold_nr = 1'b0;
    logic [511:0] ks_blk;

    logic         busy0, core_init0, core_next0, core_ready0, dov0;
    logic         in_ready0, out_valid0, out_last0, err0;
    logic [31:0]  out_data0;
    logic [15:0]  blk_cnt0;
    logic [1:0]   cnt0;

    logic         busy1, core_init1, core_next1, core_ready1, dov1;
    logic         in_ready1, out_valid1, out_last1, err1;
    logic [31:0]  out_data1;
    logic [15:0]  blk_cnt1;
    logic [1:0]   cnt1;

    logic         sel = 1'b0;
    logic         m_busy, m_in_ready, m_out_valid, m_out_last;
    logic [31:0]  m_out_data;

    int   ncmp = 0;
    int   nfail = 0;
    int   widx = 0;
    int   ninit0 = 0, nnext0 = 0, ninit1 = 0, nnext1 = 0;
    int   base_i, base_n;
    exp_t sbq[$];

    chacha_stream_xor #(.MAX_BLOCKS(0)) u0 (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .busy                (busy0),
        .core_init           (core_init0),
        .core_next           (core_next0),
        .core_ready          (core_ready0),
        .core_data_out       (ks_blk),
        .core_data_out_valid (dov0),
        .in_valid            (in_valid),
        .in_ready            (in_ready0),
        .in_data             (in_data),
        .in_last             (in_last),
        .out_valid           (out_valid0),
        .out_ready           (out_ready),
        .out_data            (out_data0),
        .out_last            (out_last0),
        .blk_cnt             (blk_cnt0),
        .err                 (err0)
    );

    chacha_stream_xor #(.MAX_BLOCKS(1)) u1 (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .busy                (busy1),
        .core_init           (core_init1),
        .core_next           (core_next1),
        .core_ready          (core_ready1),
        .core_data_out       (ks_blk),
        .core_data_out_valid (dov1),
        .in_valid            (in_valid),
        .in_ready            (in_ready1),
        .in_data             (in_data),
        .in_last             (in_last),
        .out_valid           (out_valid1),
        .out_ready           (out_ready),
        .out_data            (out_data1),
        .out_last            (out_last1),
        .blk_cnt             (blk_cnt1),
        .err                 (err1)
    );

    always #5 clk = ~clk;

    // Stub cores: block ready three cycles after a request.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0 <= 2'd0;
            dov0 <= 1'b0;
        end else if (core_init0 || core_next0) begin
            cnt0 <= 2'd3;
            dov0 <= 1'b0;
        end else if (cnt0 != 2'd0) begin
            cnt0 <= cnt0 - 2'd1;
            if (cnt0 == 2'd1) dov0 <= 1'b1;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt1 <= 2'd0;
            dov1 <= 1'b0;
        end else if (core_init1 || core_next1) begin
            cnt1 <= 2'd3;
            dov1 <= 1'b0;
        end else if (cnt1 != 2'd0) begin
            cnt1 <= cnt1 - 2'd1;
            if (cnt1 == 2'd1) dov1 <= 1'b1;
        end
    end

    assign core_ready0 = (cnt0 == 2'd0) && !hold_nr;
    assign core_ready1 = (cnt1 == 2'd0) && !hold_nr;

    assign m_busy      = sel ? busy1      : busy0;
    assign m_in_ready  = sel ? in_ready1  : in_ready0;
    assign m_out_valid = sel ? out_valid1 : out_valid0;
    assign m_out_data  = sel ? out_data1  : out_data0;
    assign m_out_last  = sel ? out_last1  : out_last0;

    // Count cycles in which each request line is high.
    always @(negedge clk) begin
        if (core_init0) ninit0++;
        if (core_next0) nnext0++;
        if (core_init1) ninit1++;
        if (core_next1) nnext1++;
    end

    function automatic logic [31:0] ks_word(input int i);
        return 32'hA5A50000 + 32'(i % 16);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop and compare on each output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (m_out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                ncmp++;
                assert (sbq.size() != 0) else begin
                    nfail++;
                    $error("FAIL sb_extra: observed word %0h expected none",
                           m_out_data);
                end
            end else begin
                e = sbq.pop_front();
                chk("out_data", 64'(m_out_data), 64'(e.data));
                chk("out_last", 64'(m_out_last), 64'(e.last));
            end
        end
    end

    task automatic start_session();
        widx  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int n, input logic [31:0] v,
                        input bit last_on_end);
        int  t;
        bit  ok;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = v;
            in_last  = last_on_end && (k == n - 1);
            ok = 1'b0;
            t  = 0;
            while (!ok && t < 100) begin
                @(negedge clk);
                if (m_in_ready) begin
                    sbq.push_back('{last: in_last,
                                    data: v ^ ks_word(widx)});
                    widx++;
                    ok = 1'b1;
                end
                @(posedge clk); #1;
                t++;
            end
            if (!ok) begin
                chk("in_timeout", 64'(ok), 64'(1));
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (m_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(m_busy), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            ks_blk[511-32*i -: 32] = 32'hA5A50000 + 32'(i);

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     64'(busy0),      64'(0));
        chk("rst_init",     64'(core_init0), 64'(0));
        chk("rst_next",     64'(core_next0), 64'(0));
        chk("rst_in_ready", 64'(in_ready0),  64'(0));
        chk("rst_out_vld",  64'(out_valid0), 64'(0));
        chk("rst_out_last", 64'(out_last0),  64'(0));
        chk("rst_out_data", 64'(out_data0),  64'(0));
        chk("rst_blk_cnt",  64'(blk_cnt0),   64'(0));
        chk("rst_err",      64'(err0),       64'(0));
        chk("rst_busy1",    64'(busy1),      64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Three zero words: keystream passes through.
        base_i = ninit0;
        base_n = nnext0;
        start_session();
        send(3, 32'h0, 1'b1);
        wait_idle();
        chk("t1_init",  64'(ninit0),     64'(base_i + 1));
        chk("t1_next",  64'(nnext0),     64'(base_n));
        chk("t1_blk",   64'(blk_cnt0),   64'(1));
        chk("t1_sb",    64'(sbq.size()), 64'(0));

        // Twenty all-ones words span two blocks.
        base_i = ninit0;
        base_n = nnext0;
        start_session();
        send(20, 32'hFFFFFFFF, 1'b1);
        wait_idle();
        chk("t2_init",  64'(ninit0),     64'(base_i + 1));
        chk("t2_next",  64'(nnext0),     64'(base_n + 1));
        chk("t2_blk",   64'(blk_cnt0),   64'(2));
        chk("t2_sb",    64'(sbq.size()), 64'(0));

        // Output stall mid-block.
        start_session();
        send(4, 32'h13572468, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h13572468;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready0),  64'(0));
            chk("stall_out_vld",  64'(out_valid0), 64'(1));
            chk("stall_out_data", 64'(out_data0),
                64'(32'h13572468 ^ ks_word(3)));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4, 32'h13572468, 1'b1);
        wait_idle();
        chk("t3_sb",    64'(sbq.size()), 64'(0));
        chk("t3_blk",   64'(blk_cnt0),   64'(1));

        // Core busy after start holds back init.
        base_i  = ninit0;
        hold_nr = 1'b1;
        start_session();
        repeat (10) begin
            @(negedge clk);
            chk("hold_init", 64'(core_init0), 64'(0));
        end
        @(posedge clk); #1;
        hold_nr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_init_once", 64'(ninit0), 64'(base_i + 1));
        send(1, 32'h12345678, 1'b1);
        wait_idle();

        // Asynchronous reset mid-block.
        start_session();
        send(7, 32'h0F0F0F0F, 1'b0);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("arst_busy",    64'(busy0),      64'(0));
        chk("arst_out_vld", 64'(out_valid0), 64'(0));
        chk("arst_data",    64'(out_data0),  64'(0));
        chk("arst_blk",     64'(blk_cnt0),   64'(0));
        chk("arst_in_rdy",  64'(in_ready0),  64'(0));
        sbq.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        base_i = ninit0;
        base_n = nnext0;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_no_init", 64'(ninit0), 64'(base_i));
        chk("arst_no_next", 64'(nnext0), 64'(base_n));
        start_session();
        repeat (2) @(posedge clk);
        #1;
        chk("arst_reinit",  64'(ninit0), 64'(base_i + 1));
        send(1, 32'hCAFEF00D, 1'b1);
        wait_idle();

        // One-block limit on the second instance.
        sel    = 1'b1;
        base_n = nnext1;
        start_session();
        send(16, 32'h0, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h0;
        repeat (6) begin
            @(negedge clk);
            chk("lim_held", 64'(in_ready1), 64'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();
        chk("lim_err",  64'(err1),       64'(1));
        chk("lim_next", 64'(nnext1),     64'(base_n));
        chk("lim_blk",  64'(blk_cnt1),   64'(1));
        chk("lim_sb",   64'(sbq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
